gelato_fetch_scheduler: RTL and testbench

Picks one warp per cycle to fetch from the PC table. It issues that warp's PC and split-table number to the instruction-fetch stage over a valid/ready handshake, and keeps each warp to one outstanding fetch. It sits between the PC table (slave side of `gelato_pctable_fetchskd_if`) and the I-cache/fetch unit. Arbitration is round-robin, and eligibility is gated by per-warp activation and instruction-buffer backpressure.

---
 rtl/gelato_types.sv | 30 +++
 rtl/gelato_pctable_fetchskd_if.sv | 27 ++
 rtl/gelato_rr_arbiter.sv | 26 ++
 rtl/gelato_fetch_scheduler.sv | 118 +++++++++++
 tb/tb_gelato_fetch_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gelato_types.sv
// Shared gelato types for the warp fetch path: warp ids, addresses, split-table ids, fetch state.
// Latency: none, types and widths only.
// Backpressure: not applicable.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

package gelato_types;

    localparam int WARP_NUM_W    = (`WARP_NUM > 1) ? $clog2(`WARP_NUM) : 1;
    localparam int ADDR_W        = 32;
    localparam int SPLIT_TABLE_W = 4;

    typedef logic [WARP_NUM_W-1:0]    warp_num_t;
    typedef logic [ADDR_W-1:0]        addr_t;
    typedef logic [SPLIT_TABLE_W-1:0] split_table_num_t;

    // Per-warp fetch progress: not started, may fetch, waiting for the fetch to land.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        INFLIGHT = 2'd2
    } warp_fetch_state_t;

    // Round-robin successor of a warp id, wrapping at the warp count.
    function automatic warp_num_t rr_next(input warp_num_t w, input int n);
        return (int'(w) == n - 1) ? '0 : warp_num_t'(int'(w) + 1);
    endfunction

endpackage

// File: rtl/gelato_pctable_fetchskd_if.sv
// PC table to fetch scheduler link: per-warp PC/split-table view plus warp activation pulse.
// Latency: none, wires only.
// Backpressure: none, the PC table view is level-sampled and activation is a one-cycle pulse.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

interface gelato_pctable_fetchskd_if #(
    parameter int WARP_NUM = `WARP_NUM
);
    import gelato_types::*;

    logic [WARP_NUM-1:0] valid;
    addr_t               pc              [WARP_NUM];
    split_table_num_t    split_table_num [WARP_NUM];
    logic                activate_valid;
    warp_num_t           activate_warp_num;

    modport master (
        output valid, pc, split_table_num, activate_valid, activate_warp_num
    );

    modport slave (
        input  valid, pc, split_table_num, activate_valid, activate_warp_num
    );

endinterface

// File: rtl/gelato_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed and moves ptr.
module gelato_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan farthest-to-nearest so the candidate closest to ptr is the last (winning) write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Picks one eligible warp per cycle (round-robin) and issues its PC to fetch, one fetch in flight per warp.
// Latency: eligibility in cycle N gives fetch_valid in N+1; activation in N gives earliest fetch_valid in N+2.
// Backpressure: while fetch_valid && !fetch_ready all fetch outputs and the rr pointer hold.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

module gelato_fetch_scheduler
    import gelato_types::*;
#(
    parameter int WARP_NUM = `WARP_NUM
) (
    input  logic                     clk,
    input  logic                     rst,
    gelato_pctable_fetchskd_if.slave pctable,
    input  logic [WARP_NUM-1:0]      ibuf_full,
    output logic                     fetch_valid,
    input  logic                     fetch_ready,
    output warp_num_t                fetch_warp_num,
    output addr_t                    fetch_pc,
    output split_table_num_t         fetch_split_table_num,
    input  logic                     fetch_done_valid,
    input  warp_num_t                fetch_done_warp_num
);

    warp_fetch_state_t   warp_state [WARP_NUM];
    warp_num_t           rr_ptr;
    logic [WARP_NUM-1:0] eligible;
    logic                handshake;
    logic                arb_en;
    logic                grant_valid;
    warp_num_t           grant_idx;

    assign handshake = fetch_valid && fetch_ready;
    // The output register may be reloaded when it is empty or emptying this cycle.
    assign arb_en    = !fetch_valid || fetch_ready;

    // A warp may fetch when ready, its PC is valid, its buffer has room, and it is not already on the outputs.
    always_comb begin
        eligible = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            eligible[w] = (warp_state[w] == READY) && pctable.valid[w] && !ibuf_full[w]
                       && !(fetch_valid && (fetch_warp_num == warp_num_t'(w)));
        end
    end

    gelato_rr_arbiter #(
        .N     (WARP_NUM),
        .IDX_W (WARP_NUM_W)
    ) u_rr_arbiter (
        .req         (eligible),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Per-warp lifecycle; each transition only fires from its source state, so stray events are no-ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WARP_NUM; w++) begin
                warp_state[w] <= IDLE;
            end
        end else begin
            for (int w = 0; w < WARP_NUM; w++) begin
                case (warp_state[w])
                    IDLE: begin
                        if (pctable.activate_valid && (pctable.activate_warp_num == warp_num_t'(w))) begin
                            warp_state[w] <= READY;
                        end
                    end
                    READY: begin
                        if (handshake && (fetch_warp_num == warp_num_t'(w))) begin
                            warp_state[w] <= INFLIGHT;
                        end
                    end
                    INFLIGHT: begin
                        if (fetch_done_valid && (fetch_done_warp_num == warp_num_t'(w))) begin
                            warp_state[w] <= READY;
                        end
                    end
                    default: warp_state[w] <= IDLE;
                endcase
            end
        end
    end

    // Output register: PC and split-table entry are captured at grant so later PC-table writes cannot alter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid           <= 1'b0;
            fetch_warp_num        <= '0;
            fetch_pc              <= '0;
            fetch_split_table_num <= '0;
            rr_ptr                <= '0;
        end else if (arb_en) begin
            if (grant_valid) begin
                fetch_valid           <= 1'b1;
                fetch_warp_num        <= grant_idx;
                fetch_pc              <= pctable.pc[grant_idx];
                fetch_split_table_num <= pctable.split_table_num[grant_idx];
                rr_ptr                <= rr_next(grant_idx, WARP_NUM);
            end else begin
                fetch_valid <= 1'b0;
            end
        end
    end

    // Flag done pulses that do not match an outstanding fetch; the state machine ignores them.
    always_ff @(posedge clk) begin
        if (!rst && fetch_done_valid) begin
            assert (warp_state[fetch_done_warp_num] == INFLIGHT)
                else $error("gelato_fetch_scheduler: done for warp %0d with no fetch in flight", fetch_done_warp_num);
            assert (!(handshake && (fetch_warp_num == fetch_done_warp_num)))
                else $error("gelato_fetch_scheduler: done for warp %0d in its own accept cycle", fetch_done_warp_num);
        end
    end

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Directed bench for gelato_fetch_scheduler with a request scoreboard.
// Latency: checks cycle-exact issue timing after activation, done and reset.
// Backpressure: exercises fetch_ready stalls and ibuf_full / pc-valid gating.
module tb_gelato_fetch_scheduler;
    import gelato_types::*;

    localparam int WN = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WN-1:0]    ibuf_full;
    logic             fetch_valid;
    logic             fetch_ready;
    warp_num_t        fetch_warp_num;
    addr_t            fetch_pc;
    split_table_num_t fetch_split_table_num;
    logic             fetch_done_valid;
    warp_num_t        fetch_done_warp_num;

    gelato_pctable_fetchskd_if #(.WARP_NUM(WN)) pif ();

    gelato_fetch_scheduler #(.WARP_NUM(WN)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pctable               (pif),
        .ibuf_full             (ibuf_full),
        .fetch_valid           (fetch_valid),
        .fetch_ready           (fetch_ready),
        .fetch_warp_num        (fetch_warp_num),
        .fetch_pc              (fetch_pc),
        .fetch_split_table_num (fetch_split_table_num),
        .fetch_done_valid      (fetch_done_valid),
        .fetch_done_warp_num   (fetch_done_warp_num)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        warp_num_t        w;
        addr_t            pc;
        split_table_num_t stn;
    } req_t;

    req_t      exp_q[$];
    int        n_cmp = 0;
    int        n_err = 0;
    int        n_hs  = 0;
    logic      hs_flag;
    warp_num_t hs_w;
    logic      pend_vld;
    warp_num_t pend_w;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int w, input logic [31:0] pc, input int stn);
        req_t e;
        e.w   = warp_num_t'(w);
        e.pc  = pc;
        e.stn = split_table_num_t'(stn);
        exp_q.push_back(e);
    endtask

    // Score the transfer this edge completes (sampled mid-cycle), then advance to just after the edge.
    task automatic tick();
        req_t e;
        hs_flag = 1'b0;
        if (!rst && fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
            hs_flag = 1'b1;
            hs_w    = fetch_warp_num;
            n_hs++;
            if (exp_q.size() == 0) begin
                cmp("unexpected_req", 32'(fetch_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                cmp("hs_warp", 32'(fetch_warp_num), 32'(e.w));
                cmp("hs_pc", fetch_pc, e.pc);
                cmp("hs_stn", 32'(fetch_split_table_num), 32'(e.stn));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_pulses();
        pif.activate_valid  = 1'b0;
        fetch_done_valid    = 1'b0;
        fetch_done_warp_num = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet_pulses();
        tick();
        rst  = 1'b0;
        n_hs = 0;
        pend_vld = 1'b0;
        pend_w   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fetch_ready = 1'b0;
        ibuf_full = '0;
        pif.valid = '0;
        pif.activate_warp_num = '0;
        quiet_pulses();
        for (int w = 0; w < WN; w++) begin
            pif.pc[w] = '0;
            pif.split_table_num[w] = '0;
        end
        pend_vld = 1'b0;
        pend_w   = '0;

        // Reset held two cycles under random inputs.
        repeat (2) begin
            fetch_ready            = 1'($urandom);
            ibuf_full              = WN'($urandom);
            pif.valid              = WN'($urandom);
            pif.activate_valid     = 1'($urandom);
            pif.activate_warp_num  = warp_num_t'($urandom);
            fetch_done_valid       = 1'($urandom);
            fetch_done_warp_num    = warp_num_t'($urandom);
            for (int w = 0; w < WN; w++) begin
                pif.pc[w] = addr_t'($urandom);
                pif.split_table_num[w] = split_table_num_t'($urandom);
            end
            tick();
        end
        rst = 1'b0;
        quiet_pulses();
        ibuf_full = '0;
        pif.valid = '1;
        fetch_ready = 1'b1;
        cmp("rst_valid", 32'(fetch_valid), 32'd0);
        cmp("rst_warp", 32'(fetch_warp_num), 32'd0);
        cmp("rst_pc", fetch_pc, 32'd0);
        cmp("rst_stn", 32'(fetch_split_table_num), 32'd0);
        repeat (3) begin
            tick();
            cmp("no_req_before_activate", 32'(fetch_valid), 32'd0);
        end

        // Two-warp issue back to back.
        do_reset();
        pif.pc[0] = 32'h100; pif.split_table_num[0] = 4'h1;
        pif.pc[2] = 32'h200; pif.split_table_num[2] = 4'h3;
        pif.activate_valid = 1'b1; pif.activate_warp_num = 2'd0;
        push_exp(0, 32'h100, 1);
        tick();
        cmp("p1_act_n1_valid", 32'(fetch_valid), 32'd0);
        pif.activate_warp_num = 2'd2;
        push_exp(2, 32'h200, 3);
        tick();
        pif.activate_valid = 1'b0;
        cmp("p1_act_n2_valid", 32'(fetch_valid), 32'd1);
        cmp("p1_first_warp", 32'(fetch_warp_num), 32'd0);
        tick();
        cmp("p1_second_valid", 32'(fetch_valid), 32'd1);
        cmp("p1_second_warp", 32'(fetch_warp_num), 32'd2);
        tick();
        cmp("p1_drain_valid", 32'(fetch_valid), 32'd0);
        cmp("p1_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure with a PC-table write during the stall.
        do_reset();
        fetch_ready = 1'b0;
        pif.pc[1] = 32'h340; pif.split_table_num[1] = 4'h2;
        pif.activate_valid = 1'b1; pif.activate_warp_num = 2'd1;
        tick();
        pif.activate_valid = 1'b0;
        tick();
        cmp("p2_pending_valid", 32'(fetch_valid), 32'd1);
        pif.pc[1] = 32'h400;
        repeat (3) begin
            tick();
            cmp("p2_stall_valid", 32'(fetch_valid), 32'd1);
            cmp("p2_stall_warp", 32'(fetch_warp_num), 32'd1);
            cmp("p2_stall_pc", fetch_pc, 32'h340);
        end
        push_exp(1, 32'h340, 2);
        fetch_ready = 1'b1;
        tick();
        cmp("p2_no_self_regrant", 32'(fetch_valid), 32'd0);
        cmp("p2_q_empty", 32'(exp_q.size()), 32'd0);
        fetch_done_valid = 1'b1; fetch_done_warp_num = 2'd1;
        push_exp(1, 32'h400, 2);
        tick();
        fetch_done_valid = 1'b0;
        cmp("p2_done_n1_valid", 32'(fetch_valid), 32'd0);
        tick();
        cmp("p2_done_n2_valid", 32'(fetch_valid), 32'd1);
        tick();
        cmp("p2_q_empty_after_redirect", 32'(exp_q.size()), 32'd0);

        // Fairness: all four warps, done one cycle after each of the first four accepts.
        do_reset();
        for (int w = 0; w < WN; w++) begin
            pif.pc[w] = addr_t'(32'h1000 + w * 16);
            pif.split_table_num[w] = split_table_num_t'(w + 1);
        end
        for (int k = 0; k < 8; k++) begin
            push_exp(k % 4, addr_t'(32'h1000 + (k % 4) * 16), (k % 4) + 1);
        end
        for (int c = 0; c < 20; c++) begin
            pif.activate_valid    = (c < 4);
            pif.activate_warp_num = warp_num_t'(c % 4);
            fetch_done_valid      = pend_vld;
            fetch_done_warp_num   = pend_w;
            tick();
            pend_vld = hs_flag && (n_hs <= 4);
            pend_w   = hs_w;
        end
        quiet_pulses();
        cmp("p3_q_empty", 32'(exp_q.size()), 32'd0);
        cmp("p3_idle_valid", 32'(fetch_valid), 32'd0);

        // Gating by ibuf_full and pc valid, then releasing warp 1.
        do_reset();
        ibuf_full = 4'b0010;
        pif.valid = 4'b0111;
        push_exp(0, 32'h1000, 1);
        push_exp(2, 32'h1020, 3);
        push_exp(0, 32'h1000, 1);
        push_exp(2, 32'h1020, 3);
        push_exp(0, 32'h1000, 1);
        push_exp(1, 32'h1010, 2);
        for (int c = 0; c < 20; c++) begin
            pif.activate_valid    = (c < 4);
            pif.activate_warp_num = warp_num_t'(c % 4);
            fetch_done_valid      = pend_vld;
            fetch_done_warp_num   = pend_w;
            tick();
            pend_vld = hs_flag && (n_hs <= 3);
            pend_w   = hs_w;
            if (n_hs >= 4) ibuf_full[1] = 1'b0;
        end
        quiet_pulses();
        cmp("p4_q_empty", 32'(exp_q.size()), 32'd0);
        cmp("p4_idle_valid", 32'(fetch_valid), 32'd0);

        // Re-activation while in flight is ignored; reset drops a pending request.
        do_reset();
        pif.valid = '1;
        ibuf_full = '0;
        pif.pc[3] = 32'h3300; pif.split_table_num[3] = 4'h7;
        push_exp(3, 32'h3300, 7);
        pif.activate_valid = 1'b1; pif.activate_warp_num = 2'd3;
        tick();
        pif.activate_valid = 1'b0;
        tick();
        tick();
        cmp("p5_q_empty", 32'(exp_q.size()), 32'd0);
        pif.activate_valid = 1'b1; pif.activate_warp_num = 2'd3;
        tick();
        pif.activate_valid = 1'b0;
        repeat (3) begin
            tick();
            cmp("p5_reactivate_ignored", 32'(fetch_valid), 32'd0);
        end
        fetch_done_valid = 1'b1; fetch_done_warp_num = 2'd3;
        tick();
        fetch_done_valid = 1'b0;
        fetch_ready = 1'b0;
        tick();
        cmp("p5_pending_valid", 32'(fetch_valid), 32'd1);
        cmp("p5_pending_warp", 32'(fetch_warp_num), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("p5_rst_drop_valid", 32'(fetch_valid), 32'd0);
        cmp("p5_rst_drop_pc", fetch_pc, 32'd0);
        fetch_ready = 1'b1;
        repeat (3) begin
            tick();
            cmp("p5_after_rst_valid", 32'(fetch_valid), 32'd0);
        end
        cmp("p5_final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
